// File: rtl/ram_cycle_seq_pkg.sv
// Shared types for the DRAM cycle sequencer.
//   state_e : sequencer FSM states
//   owner_e : who owns the current memory cycle
//   *_DEF   : default parameter values used by ram_cycle_seq
package ram_cycle_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW,
    ST_COL,
    ST_CAS,
    ST_CBR_CAS,
    ST_CBR_RAS
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_CPU,
    OWN_REF
  } owner_e;

  localparam int unsigned ROW_W_DEF       = 10;
  localparam int unsigned REFRESH_DIV_DEF = 64;
  localparam int unsigned PEND_MAX_DEF    = 3;

endpackage

// File: rtl/ram_cycle_seq_strobe_edge.sv
// Two-flop strobe sampler with edge detection.
//   clk, res : clock, synchronous active-high reset
//   d        : raw strobe from the clock generator
//   level    : strobe after one register stage (s_x)
//   rise     : s_x & ~p_x, one clk wide
//   fall     : ~s_x & p_x, one clk wide
module ram_cycle_seq_strobe_edge (
  input  logic clk,
  input  logic res,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s_q, s_d;
  logic p_q, p_d;

  always_comb begin
    s_d = d;
    p_d = s_q;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      s_q <= 1'b0;
      p_q <= 1'b0;
    end else begin
      s_q <= s_d;
      p_q <= p_d;
    end
  end

  assign level = s_q;
  assign rise  = s_q & ~p_q;
  assign fall  = ~s_q & p_q;

endmodule

// File: rtl/ram_cycle_seq.sv
// DRAM cycle sequencer.
// Turns the clock generator's timing strobes into RAS/CAS/WE sequences with a
// muxed row/column address, arbitrating each 8-clk memory cycle between the
// video port, the CPU port and CAS-before-RAS refresh.
//   clk, res               : clock, synchronous active-high reset
//   time0/addrsel/latch    : cycle start/end, row->col switch, CAS point
//   cycsel                 : slot type at cycle start (1 video, 0 CPU)
//   vid_req/vid_addr/ack   : video fetch port, {row,col} address
//   cpu_req/we/addr/ack    : CPU port, {row,col} address
//   ram_addr, ras_n, cas_n, we_n : DRAM interface (registered)
//   refresh_busy           : high during a refresh cycle
module ram_cycle_seq
  import ram_cycle_seq_pkg::*;
#(
  parameter int unsigned ROW_W       = ROW_W_DEF,
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEF,
  parameter int unsigned PEND_MAX    = PEND_MAX_DEF
) (
  input  logic               clk,
  input  logic               res,
  input  logic               time0,
  input  logic               addrsel,
  input  logic               latch,
  input  logic               cycsel,
  input  logic               vid_req,
  input  logic [2*ROW_W-1:0] vid_addr,
  output logic               vid_ack,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [2*ROW_W-1:0] cpu_addr,
  output logic               cpu_ack,
  output logic [ROW_W-1:0]   ram_addr,
  output logic               ras_n,
  output logic               cas_n,
  output logic               we_n,
  output logic               refresh_busy
);

  localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned PEND_W = $clog2(PEND_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

  // Strobe edges
  logic t0_lvl, t0_rise, t0_fall;
  logic as_lvl, as_rise, as_fall;
  logic la_lvl, la_rise, la_fall;
  logic cyc_lvl, cyc_rise, cyc_fall;

  ram_cycle_seq_strobe_edge u_time0 (
    .clk(clk), .res(res), .d(time0), .level(t0_lvl), .rise(t0_rise), .fall(t0_fall)
  );
  ram_cycle_seq_strobe_edge u_addrsel (
    .clk(clk), .res(res), .d(addrsel), .level(as_lvl), .rise(as_rise), .fall(as_fall)
  );
  ram_cycle_seq_strobe_edge u_latch (
    .clk(clk), .res(res), .d(latch), .level(la_lvl), .rise(la_rise), .fall(la_fall)
  );
  // cycsel goes through the same delay as time0 so its level lines up with t0_rise
  ram_cycle_seq_strobe_edge u_cycsel (
    .clk(clk), .res(res), .d(cycsel), .level(cyc_lvl), .rise(cyc_rise), .fall(cyc_fall)
  );

  logic unused_strobes;
  assign unused_strobes = ^{t0_lvl, as_lvl, as_fall, la_lvl, la_fall, cyc_rise, cyc_fall};

  // State
  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ROW_W-1:0]   col_q, col_d;
  logic               wr_q, wr_d;
  logic [CNT_W-1:0]   refcnt_q, refcnt_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic [ROW_W-1:0]   ram_addr_q, ram_addr_d;
  logic               ras_n_q, ras_n_d;
  logic               cas_n_q, cas_n_d;
  logic               we_n_q, we_n_d;
  logic               busy_q, busy_d;
  logic               vid_ack_q, vid_ack_d;
  logic               cpu_ack_q, cpu_ack_d;

  owner_e sel;
  logic   acc_done, ref_done, wrap;

  // State register
  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      row_q      <= '0;
      col_q      <= '0;
      wr_q       <= 1'b0;
      refcnt_q   <= '0;
      pend_q     <= '0;
      ram_addr_q <= '0;
      ras_n_q    <= 1'b1;
      cas_n_q    <= 1'b1;
      we_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wr_q       <= wr_d;
      refcnt_q   <= refcnt_d;
      pend_q     <= pend_d;
      ram_addr_q <= ram_addr_d;
      ras_n_q    <= ras_n_d;
      cas_n_q    <= cas_n_d;
      we_n_q     <= we_n_d;
      busy_q     <= busy_d;
      vid_ack_q  <= vid_ack_d;
      cpu_ack_q  <= cpu_ack_d;
    end
  end

  // Next state and owner selection
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    row_d   = row_q;
    col_d   = col_q;
    wr_d    = wr_q;

    // A full pending count overrides the CPU; video slots are never stolen
    // from a waiting video request.
    sel = OWN_NONE;
    if (cyc_lvl) begin
      if (vid_req)              sel = OWN_VID;
      else if (pend_q != '0)    sel = OWN_REF;
    end else begin
      if (pend_q == PEND_FULL)  sel = OWN_REF;
      else if (cpu_req)         sel = OWN_CPU;
      else if (pend_q != '0)    sel = OWN_REF;
    end

    case (state_q)
      ST_IDLE: begin
        if (t0_rise) begin
          owner_d = sel;
          case (sel)
            OWN_VID: begin
              state_d = ST_ROW;
              row_d   = vid_addr[2*ROW_W-1:ROW_W];
              col_d   = vid_addr[ROW_W-1:0];
              wr_d    = 1'b0;
            end
            OWN_CPU: begin
              state_d = ST_ROW;
              row_d   = cpu_addr[2*ROW_W-1:ROW_W];
              col_d   = cpu_addr[ROW_W-1:0];
              wr_d    = cpu_we;
            end
            OWN_REF: state_d = ST_CBR_CAS;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      // time0 fall takes priority everywhere: an unfinished cycle is aborted
      ST_ROW:     if (t0_fall) state_d = ST_IDLE; else if (as_rise) state_d = ST_COL;
      ST_COL:     if (t0_fall) state_d = ST_IDLE; else if (la_rise) state_d = ST_CAS;
      ST_CAS:     if (t0_fall) state_d = ST_IDLE;
      ST_CBR_CAS: if (t0_fall) state_d = ST_IDLE; else if (as_rise) state_d = ST_CBR_RAS;
      ST_CBR_RAS: if (t0_fall) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) owner_d = OWN_NONE;
  end

  // Refresh counter and pending count
  always_comb begin
    acc_done = (state_q == ST_CAS) && t0_fall;
    ref_done = (state_q == ST_CBR_RAS) && t0_fall;
    wrap     = t0_rise && (refcnt_q == CNT_LAST);

    refcnt_d = refcnt_q;
    if (t0_rise) refcnt_d = wrap ? '0 : refcnt_q + 1'b1;

    pend_d = pend_q;
    if (wrap && !ref_done) begin
      if (pend_q != PEND_FULL) pend_d = pend_q + 1'b1;
    end else if (ref_done && !wrap) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Registered outputs, decoded from the state being entered
  always_comb begin
    ras_n_d    = 1'b1;
    cas_n_d    = 1'b1;
    we_n_d     = 1'b1;
    busy_d     = 1'b0;
    ram_addr_d = ram_addr_q;
    vid_ack_d  = acc_done && (owner_q == OWN_VID);
    cpu_ack_d  = acc_done && (owner_q == OWN_CPU);

    case (state_d)
      ST_ROW: begin
        ras_n_d    = 1'b0;
        ram_addr_d = row_d;
      end
      ST_COL: begin
        ras_n_d    = 1'b0;
        ram_addr_d = col_d;
        we_n_d     = (owner_d == OWN_CPU) ? ~wr_d : 1'b1;
      end
      ST_CAS: begin
        ras_n_d    = 1'b0;
        cas_n_d    = 1'b0;
        ram_addr_d = col_d;
        we_n_d     = (owner_d == OWN_CPU) ? ~wr_d : 1'b1;
      end
      ST_CBR_CAS: begin
        cas_n_d = 1'b0;
        busy_d  = 1'b1;
      end
      ST_CBR_RAS: begin
        cas_n_d = 1'b0;
        ras_n_d = 1'b0;
        busy_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ram_addr     = ram_addr_q;
  assign ras_n        = ras_n_q;
  assign cas_n        = cas_n_q;
  assign we_n         = we_n_q;
  assign refresh_busy = busy_q;
  assign vid_ack      = vid_ack_q;
  assign cpu_ack      = cpu_ack_q;

endmodule

// File: tb/tb_ram_cycle_seq.sv
module tb_ram_cycle_seq;

  localparam int unsigned ROW_W       = 10;
  localparam int unsigned REFRESH_DIV = 64;
  localparam int unsigned PEND_MAX    = 3;
  localparam int K_VID = 1;
  localparam int K_CPU = 2;
  localparam int K_REF = 3;

  logic clk = 1'b0;
  logic res, time0, addrsel, latch, cycsel;
  logic vid_req, cpu_req, cpu_we;
  logic [2*ROW_W-1:0] vid_addr, cpu_addr;
  logic vid_ack, cpu_ack, ras_n, cas_n, we_n, refresh_busy;
  logic [ROW_W-1:0] ram_addr;

  always #5 clk = ~clk;

  ram_cycle_seq #(
    .ROW_W(ROW_W),
    .REFRESH_DIV(REFRESH_DIV),
    .PEND_MAX(PEND_MAX)
  ) dut (
    .clk(clk), .res(res), .time0(time0), .addrsel(addrsel), .latch(latch),
    .cycsel(cycsel), .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .refresh_busy(refresh_busy)
  );

  typedef struct {
    int               kind;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] col;
    logic             we_n;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model of arbitration / refresh bookkeeping
  int  m_cnt, m_pend;
  bit  hold_vid, hold_cpu;
  time t0_fall_time;

  // Monitor state
  int  mode;  // 0 none, 1 access, 2 refresh
  logic prev_ras = 1'b1, prev_cas = 1'b1;
  logic [ROW_W-1:0] row_seen, col_seen;
  logic we_seen;
  int strobe_low_cnt = 0;
  int ref_cnt = 0;

  task automatic finish_txn(input int kind);
    exp_t e;
    check_eq("done_latency", 32'($time - t0_fall_time), 32'd24);
    check_eq("done_expected", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("done_kind", 32'(kind), 32'(e.kind));
      if (kind != K_REF) begin
        check_eq("row_addr", 32'(row_seen), 32'(e.row));
        check_eq("col_addr", 32'(col_seen), 32'(e.col));
        check_eq("we_n_col", 32'(we_seen), 32'(e.we_n));
        check_eq("single_ack_owner", 32'(vid_ack & cpu_ack), 32'd0);
      end else begin
        check_eq("ref_no_ack", 32'(vid_ack | cpu_ack), 32'd0);
        check_eq("ref_busy_off", 32'(refresh_busy), 32'd0);
        ref_cnt++;
      end
    end
    mode = 0;
  endtask

  always @(negedge clk) begin
    if (res) begin
      mode     = 0;
      prev_ras = 1'b1;
      prev_cas = 1'b1;
    end else begin
      if (!ras_n || !cas_n || !we_n) strobe_low_cnt++;
      if (prev_ras && !ras_n && cas_n) begin
        check_eq("acc_start_expected",
                 32'((exp_q.size() > 0) && (exp_q[0].kind != K_REF)), 32'd1);
        mode     = 1;
        row_seen = ram_addr;
      end
      if (prev_cas && !cas_n && !ras_n && mode == 1) begin
        col_seen = ram_addr;
        we_seen  = we_n;
      end
      if (prev_cas && !cas_n && ras_n) begin
        check_eq("cbr_start_expected",
                 32'((exp_q.size() > 0) && (exp_q[0].kind == K_REF)), 32'd1);
        check_eq("cbr_cas_busy", 32'(refresh_busy), 32'd1);
        mode = 2;
      end
      if (prev_ras && !ras_n && !cas_n && mode == 2)
        check_eq("cbr_ras_busy", 32'(refresh_busy), 32'd1);
      if (vid_ack || cpu_ack)
        finish_txn(vid_ack ? K_VID : K_CPU);
      else if (mode == 2 && !prev_ras && ras_n)
        finish_txn(K_REF);
      prev_ras = ras_n;
      prev_cas = cas_n;
    end
  end

  // One 8-clk memory cycle: time0 high ph0-5, addrsel rise ph2, latch rise ph4.
  task automatic run_cycle(input bit vid_slot, input bit rst_at_cas);
    exp_t e;
    int   kind;
    logic [2*ROW_W-1:0] a;
    kind = 0;
    if (vid_slot) kind = vid_req ? K_VID : (m_pend > 0 ? K_REF : 0);
    else kind = (m_pend == PEND_MAX) ? K_REF : (cpu_req ? K_CPU : (m_pend > 0 ? K_REF : 0));
    if (m_cnt == REFRESH_DIV - 1) begin
      m_cnt = 0;
      if (m_pend < PEND_MAX) m_pend++;
    end else begin
      m_cnt++;
    end
    if (kind != 0) begin
      a      = (kind == K_VID) ? vid_addr : cpu_addr;
      e.kind = kind;
      e.row  = (kind == K_REF) ? '0 : a[2*ROW_W-1:ROW_W];
      e.col  = (kind == K_REF) ? '0 : a[ROW_W-1:0];
      e.we_n = (kind == K_CPU) ? ~cpu_we : 1'b1;
      exp_q.push_back(e);
    end
    for (int ph = 0; ph < 8; ph++) begin
      @(posedge clk); #1;
      case (ph)
        0: begin time0 = 1'b1; cycsel = vid_slot; end
        2: addrsel = 1'b1;
        4: latch = 1'b1;
        6: begin
          if (rst_at_cas) begin
            check_eq("cas_low_before_reset", 32'(cas_n), 32'd0);
            res = 1'b1;
            exp_q.delete();
            m_cnt  = 0;
            m_pend = 0;
          end
          time0 = 1'b0; addrsel = 1'b0; latch = 1'b0;
          t0_fall_time = $time;
        end
        7: if (rst_at_cas) begin
          check_eq("rst_ras_n", 32'(ras_n), 32'd1);
          check_eq("rst_cas_n", 32'(cas_n), 32'd1);
          check_eq("rst_we_n", 32'(we_n), 32'd1);
          check_eq("rst_acks", 32'({vid_ack, cpu_ack}), 32'd0);
        end
        default: ;
      endcase
    end
    if (rst_at_cas) begin
      repeat (2) @(posedge clk);
      #1 res = 1'b0;
    end else begin
      if (kind == K_CPU && !hold_cpu) cpu_req = 1'b0;
      if (kind == K_VID && !hold_vid) vid_req = 1'b0;
      if (kind == K_REF) m_pend--;
    end
  endtask

  int refs_before;

  initial begin
    res = 1'b1; time0 = 1'b0; addrsel = 1'b0; latch = 1'b0; cycsel = 1'b0;
    vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    vid_addr = '0; cpu_addr = '0;
    hold_vid = 1'b0; hold_cpu = 1'b0;
    m_cnt = 0; m_pend = 0; t0_fall_time = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ras_n", 32'(ras_n), 32'd1);
    check_eq("reset_cas_n", 32'(cas_n), 32'd1);
    check_eq("reset_we_n", 32'(we_n), 32'd1);
    check_eq("reset_addr", 32'(ram_addr), 32'd0);
    check_eq("reset_acks", 32'({vid_ack, cpu_ack}), 32'd0);
    check_eq("reset_busy", 32'(refresh_busy), 32'd0);
    res = 1'b0;

    // Idle strobes, no requests: nothing happens for 10 cycles
    for (int i = 0; i < 10; i++) run_cycle(bit'(i % 2), 1'b0);
    check_eq("idle_no_strobes", 32'(strobe_low_cnt), 32'd0);

    // Counter wraps after 64 cycles, the following cycle is a refresh
    for (int i = 10; i < 70; i++) run_cycle(bit'(i % 2), 1'b0);
    check_eq("first_refresh_count", 32'(ref_cnt), 32'd1);

    // CPU read in a CPU slot: row 0x0A8, col 0x155
    cpu_addr = 20'h2A155; cpu_we = 1'b0; cpu_req = 1'b1;
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);

    // CPU write offered in a video slot is not served until the next CPU slot
    cpu_addr = 20'hC3A5B; cpu_we = 1'b1; cpu_req = 1'b1;
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);

    // Both requesting, alternating slots
    vid_addr = 20'h12345; vid_req = 1'b1; hold_vid = 1'b1;
    cpu_addr = 20'h0F0F0; cpu_we = 1'b0; cpu_req = 1'b1; hold_cpu = 1'b1;
    for (int i = 0; i < 6; i++) run_cycle(bit'(i % 2 == 0), 1'b0);
    hold_vid = 1'b0; vid_req = 1'b0;

    // Starvation: CPU slots only with cpu_req held; refresh must still win
    cpu_addr = 20'h55AAA; cpu_we = 1'b1;
    refs_before = ref_cnt;
    for (int i = 0; i < 200; i++) run_cycle(1'b0, 1'b0);
    check_eq("starve_refresh_seen", 32'(ref_cnt > refs_before), 32'd1);
    hold_cpu = 1'b0; cpu_req = 1'b0;
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0);

    // Reset while CAS is asserted, then retry
    cpu_addr = 20'h3FC01; cpu_we = 1'b1; cpu_req = 1'b1;
    run_cycle(1'b0, 1'b1);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
